lib_voq_allocator: RTL and testbench

- Single-iteration iSLIP switch allocator for an N-input × M-output router.
- Sits downstream of the per-input virtual output queues.
- Takes each VOQ's per-output valid vector as a request and returns a onehot read enable per input. The enable both pops that VOQ and selects its data.
- Also drives the crossbar's per-output input-select and output-valid signals.
- Round-robin pointers are registered state and advance only on accepted grants, giving starvation-free, desynchronising arbitration.

---
 rtl/lib_voq_allocator.sv | 110 +++++++++++
 tb/tb_lib_voq_allocator.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lib_voq_allocator.sv
// lib_voq_allocator: single-iteration iSLIP switch allocator.
// Turns per-input VOQ valid vectors into one-hot pop enables per input,
// plus crossbar per-output input-select and output-valid signals.
// Round-robin pointers move only on accepted grants. This keeps the
// arbitration starvation-free, and under full load the inputs settle
// onto a conflict-free permutation.
module lib_voq_allocator #(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce,
  input  logic [0:N*M-1] i_req,
  input  logic [0:M-1]   i_out_en,
  output logic [0:N*M-1] o_grant,
  output logic [0:N*M-1] o_out_sel,
  output logic [0:M-1]   o_out_val
);

  localparam int MW = (M > 1) ? $clog2(M) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Per-input pointer to the preferred output.
  // Per-output pointer to the preferred input.
  logic [MW-1:0] in_ptr  [N];
  logic [IW-1:0] out_ptr [M];

  // Stage-1 result: whether input i picked an output, and which one.
  logic [N-1:0]  s1_valid;
  logic [MW-1:0] s1_choice [N];

  logic [0:N*M-1] grant;
  logic           active;

  // Grants are suppressed while in reset or while the clock enable is low.
  assign active = ce & ~reset;

  // Stage 1: each input picks the first eligible output at or after its pointer.
  always_comb begin
    int idx;
    idx = 0;
    for (int i = 0; i < N; i++) begin
      s1_valid[i]  = 1'b0;
      s1_choice[i] = '0;
      for (int k = 0; k < M; k++) begin
        idx = (int'(in_ptr[i]) + k) % M;
        if (!s1_valid[i] && active && i_req[i*M+idx] && i_out_en[idx]) begin
          s1_valid[i]  = 1'b1;
          s1_choice[i] = MW'(idx);
        end
      end
    end
  end

  // Stage 2: each output grants the first input that chose it, scanning from its pointer.
  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int j = 0; j < M; j++) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = (int'(out_ptr[j]) + k) % N;
        if (!found && s1_valid[idx] && (s1_choice[idx] == MW'(j))) begin
          found            = 1'b1;
          grant[idx*M + j] = 1'b1;
        end
      end
    end
  end

  assign o_grant = grant;

  // The crossbar view is the transpose of the grant matrix.
  // An output is valid when any input drives it.
  always_comb begin
    o_out_sel = '0;
    o_out_val = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < M; j++) begin
        if (grant[i*M + j]) begin
          o_out_sel[j*N + i] = 1'b1;
          o_out_val[j]       = 1'b1;
        end
      end
    end
  end

  // On each accepted grant, the input and output pointers move one past their partner.
  // All other pointers hold their value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) in_ptr[i] <= '0;
      for (int j = 0; j < M; j++) out_ptr[j] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < M; j++) begin
          if (grant[i*M + j]) begin
            in_ptr[i]  <= MW'((j + 1) % M);
            out_ptr[j] <= IW'((i + 1) % N);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lib_voq_allocator.sv
// Directed bench for lib_voq_allocator with N = M = 4. A randomised property sweep follows.
module tb_lib_voq_allocator;

  localparam int N = 4;
  localparam int M = 4;

  localparam logic [0:15] FULL = 16'b1111_1111_1111_1111;
  localparam logic [0:3]  ALL  = 4'b1111;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic [0:15] i_req;
  logic [0:3]  i_out_en;
  logic [0:15] o_grant;
  logic [0:15] o_out_sel;
  logic [0:3]  o_out_val;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  lib_voq_allocator #(.N(N), .M(M)) dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .i_req     (i_req),
    .i_out_en  (i_out_en),
    .o_grant   (o_grant),
    .o_out_sel (o_out_sel),
    .o_out_val (o_out_val)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  task automatic checkBits(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive the inputs just after the falling edge, then let the combinational logic settle.
  task automatic applyStimulus(input logic [0:15] req, input logic [0:3] en,
                               input logic c, input logic r);
    @(negedge clk);
    i_req    = req;
    i_out_en = en;
    ce       = c;
    reset    = r;
    #1;
  endtask

  // Build the expected out_sel and out_val from the expected grant matrix.
  task automatic checkOutput(input string tag, input logic [0:15] exp_grant);
    logic [0:15] exp_sel;
    logic [0:3]  exp_val;
    exp_sel = '0;
    exp_val = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < M; j++)
        if (exp_grant[i*M+j]) begin
          exp_sel[j*N+i] = 1'b1;
          exp_val[j]     = 1'b1;
        end
    checkBits({tag, "/grant"},   32'(o_grant),   32'(exp_grant));
    checkBits({tag, "/out_sel"}, 32'(o_out_sel), 32'(exp_sel));
    checkBits({tag, "/out_val"}, 32'(o_out_val), 32'(exp_val));
  endtask

  // Expected grants for full load after reset, cycles 1..6.
  logic [0:15] full_seq [6];

  initial begin
    logic [0:15] exp;
    logic [0:15] req;
    logic [0:3]  en;
    logic [0:15] t;
    logic [0:15] elig;
    int          bad;
    int          cnt;

    full_seq[0] = 16'b1000_0000_0000_0000;
    full_seq[1] = 16'b0100_1000_0000_0000;
    full_seq[2] = 16'b0010_0100_1000_0000;
    full_seq[3] = 16'b0001_0010_0100_1000;
    full_seq[4] = 16'b1000_0001_0010_0100;
    full_seq[5] = 16'b0100_1000_0001_0010;

    i_req    = '0;
    i_out_en = '0;
    ce       = 1'b0;
    reset    = 1'b1;

    // While reset is asserted, outputs stay quiet even under full load.
    applyStimulus(FULL, ALL, 1'b1, 1'b1);
    checkOutput("reset0", 16'h0);
    applyStimulus(FULL, ALL, 1'b1, 1'b1);
    checkOutput("reset1", 16'h0);

    // A single request from input 2 to output 1 is granted in the same cycle.
    applyStimulus(16'b0000_0000_0100_0000, ALL, 1'b1, 1'b0);
    checkOutput("single", 16'b0000_0000_0100_0000);
    checkBits("single/out_val_lit", 32'(o_out_val), 32'(4'b0100));
    applyStimulus(16'h0, ALL, 1'b1, 1'b0);
    checkBits("single/out_ptr1", 32'(dut.out_ptr[1]), 32'd3);
    checkBits("single/in_ptr2",  32'(dut.in_ptr[2]),  32'd2);
    checkOutput("idle", 16'h0);

    // All four inputs contend for output 0 and are served round-robin.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(16'b1000_1000_1000_1000, ALL, 1'b1, 1'b0);
      exp = '0;
      exp[(k % 4) * M] = 1'b1;
      checkOutput($sformatf("contend%0d", k), exp);
    end

    // Output 0 is blocked, so input 0 is served on output 3.
    // Once output 0 is enabled again, input 0 moves to output 0.
    applyStimulus(16'b1001_0000_0000_0000, 4'b0111, 1'b1, 1'b0);
    checkOutput("blocked", 16'b0001_0000_0000_0000);
    applyStimulus(16'b1001_0000_0000_0000, ALL, 1'b1, 1'b0);
    checkBits("blocked/out_ptr0", 32'(dut.out_ptr[0]), 32'd1);
    checkOutput("unblocked", 16'b1000_0000_0000_0000);

    // Under full load from reset, the grants desynchronise into a permutation.
    applyStimulus(FULL, ALL, 1'b1, 1'b1);
    checkOutput("full/reset", 16'h0);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(FULL, ALL, 1'b1, 1'b0);
      checkOutput($sformatf("full%0d", c + 1), full_seq[c]);
    end

    // Pulling ce low freezes the allocator.
    // When ce returns, the sequence continues where it left off.
    applyStimulus(FULL, ALL, 1'b0, 1'b0);
    checkOutput("ce_off0", 16'h0);
    applyStimulus(FULL, ALL, 1'b0, 1'b0);
    checkOutput("ce_off1", 16'h0);
    checkBits("ce_off/in_ptr0", 32'(dut.in_ptr[0]), 32'd2);
    checkBits("ce_off/in_ptr3", 32'(dut.in_ptr[3]), 32'd3);
    applyStimulus(FULL, ALL, 1'b1, 1'b0);
    checkOutput("ce_resume", 16'b0010_0100_1000_0001);

    // A reset in mid-stream issues no grant in its own cycle.
    // The cycle after it restarts the sequence from the beginning.
    applyStimulus(FULL, ALL, 1'b1, 1'b1);
    checkOutput("midreset", 16'h0);
    applyStimulus(FULL, ALL, 1'b1, 1'b0);
    checkOutput("post_reset", 16'b1000_0000_0000_0000);

    // Random sweep: check the structural properties every cycle.
    for (int c = 0; c < 500; c++) begin
      req = 16'($urandom);
      en  = 4'($urandom);
      applyStimulus(req, en, 1'b1, 1'b0);

      bad = 0;
      for (int i = 0; i < N; i++) begin
        cnt = 0;
        for (int j = 0; j < M; j++) cnt += int'(o_grant[i*M+j]);
        if (cnt > 1) bad++;
      end
      for (int j = 0; j < M; j++) begin
        cnt = 0;
        for (int i = 0; i < N; i++) cnt += int'(o_out_sel[j*N+i]);
        if (cnt > 1) bad++;
      end
      checkBits("rand/onehot", 32'(bad), 32'd0);

      t    = '0;
      elig = '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < M; j++) begin
          t[i*M+j]    = o_out_sel[j*N+i];
          elig[i*M+j] = req[i*M+j] & en[j];
        end
      checkBits("rand/transpose", 32'(o_grant), 32'(t));
      checkBits("rand/eligible",  32'(o_grant & ~elig), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
